pdh_cmd_master: RTL and testbench

- PL-side initiator for the 32-bit PS->PL command word consumed by the PDH core. It drives that word in place of software.
- Accepts command requests over a valid/ready handshake and serialises each one as a setup phase followed by a strobe phase.
- Samples the core's 32-bit status word during the strobe and returns payload and status over a second valid/ready handshake.
- Also generates the core soft-reset (bit 31) on request.

---
 rtl/pdh_pkg.sv | 45 ++++
 rtl/pdh_cmd_master.sv | 161 ++++++++++++++++
 tb/tb_pdh_cmd_master.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/pdh_pkg.sv
// Shared types and field positions for the PDH command/status words
// exchanged between the PL command master and the PDH core.
package pdh_pkg;

    typedef enum logic [3:0] {
        CMD_IDLE    = 4'b0000,
        CMD_SET_LED = 4'b0001,
        CMD_SET_DAC = 4'b0010,
        CMD_STROBE  = 4'b1110
    } cmd_t;

    typedef enum logic [1:0] {
        RSP_OK       = 2'b00,
        RSP_MISMATCH = 2'b01,
        RSP_REJECT   = 2'b10
    } rsp_status_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_SETUP,
        S_STROBE,
        S_RESP
    } state_t;

    // Command word fields
    localparam int RST_BIT    = 31;
    localparam int CMD_HI     = 30;
    localparam int CMD_LO     = 27;
    localparam int DATA_HI    = 26;
    localparam int DATA_LO    = 0;
    // Status word fields
    localparam int CB_HI      = 7;
    localparam int CB_LO      = 0;
    localparam int LASTCMD_HI = 11;
    localparam int LASTCMD_LO = 8;
    localparam int CURCMD_HI  = 15;
    localparam int CURCMD_LO  = 12;

    // Only these codes may be issued from the request port; STROBE is internal.
    function automatic logic is_valid_cmd(input logic [3:0] code);
        return (code == CMD_IDLE) || (code == CMD_SET_LED) || (code == CMD_SET_DAC);
    endfunction

endpackage

// File: rtl/pdh_cmd_master.sv
// PL-side initiator for the PDH core command word: serialises requests into
// setup/strobe phases, samples the status word and returns a response.
module pdh_cmd_master
    import pdh_pkg::*;
#(
    parameter int SETUP_CYCLES  = 4,
    parameter int STROBE_CYCLES = 4,
    parameter int SAMPLE_DELAY  = 3,
    parameter int RST_CYCLES    = 4,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [3:0]  req_cmd_i,
    input  logic [26:0] req_data_i,
    input  logic        soft_rst_i,
    output logic [31:0] gpio_to_core_o,
    input  logic [31:0] gpio_from_core_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [7:0]  rsp_payload_o,
    output logic [1:0]  rsp_status_o,
    output logic        busy_o
);

    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_IDX  = CNT_W'(SAMPLE_DELAY - 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [31:0]      RST_WORD    = 32'h8000_0000;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        word_q, word_d;
    logic [3:0]         cmd_q, cmd_d;
    logic               pend_q, pend_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [7:0]         payload_q, payload_d;
    rsp_status_t        status_q, status_d;

    // Upper status bits are reserved by the core.
    logic unused_status_hi;
    assign unused_status_hi = ^gpio_from_core_i[31:16];

    always_comb begin
        // NOTE: every next-state value defaults to its current value first, so no path leaves a variable unassigned and no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        cmd_d       = cmd_q;
        pend_d      = pend_q | soft_rst_i;
        rsp_valid_d = rsp_valid_q;
        payload_d   = payload_q;
        status_d    = status_q;

        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    state_d = S_RESET;
                    cnt_d   = '0;
                    word_d  = RST_WORD;
                    pend_d  = 1'b0;
                end else if (req_valid_i && ready_q) begin
                    if (is_valid_cmd(req_cmd_i)) begin
                        state_d = S_SETUP;
                        cnt_d   = '0;
                        cmd_d   = req_cmd_i;
                        word_d  = {1'b0, req_cmd_i, req_data_i};
                    end else begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        payload_d   = '0;
                        status_d    = RSP_REJECT;
                    end
                end
            end
            S_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_IDLE;
                    word_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_STROBE;
                    cnt_d   = '0;
                    word_d  = {1'b0, CMD_STROBE, word_q[DATA_HI:DATA_LO]};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STROBE: begin
                if (cnt_q == SAMPLE_IDX) begin
                    payload_d = gpio_from_core_i[CB_HI:CB_LO];
                    status_d  = ((gpio_from_core_i[LASTCMD_HI:LASTCMD_LO] == cmd_q) &&
                                 (gpio_from_core_i[CURCMD_HI:CURCMD_LO] == CMD_STROBE))
                                ? RSP_OK : RSP_MISMATCH;
                end
                if (cnt_q == STROBE_LAST) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    // The data field stays put: the core keeps latching it into the DAC path.
                    word_d      = {1'b0, CMD_IDLE, word_q[DATA_HI:DATA_LO]};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE) && !pend_d;
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            word_q      <= '0;
            cmd_q       <= '0;
            pend_q      <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            payload_q   <= '0;
            status_q    <= RSP_OK;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            cmd_q       <= cmd_d;
            pend_q      <= pend_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            payload_q   <= payload_d;
            status_q    <= status_d;
        end
    end

    assign gpio_to_core_o = word_q;
    assign req_ready_o    = ready_q;
    assign busy_o         = busy_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_payload_o  = payload_q;
    assign rsp_status_o   = status_q;

endmodule

// File: tb/tb_pdh_cmd_master.sv
// Directed bench for pdh_cmd_master with a small core model that echoes the
// current command and reports programmable last-cmd/callback fields.
module tb_pdh_cmd_master;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cmd;
    logic [26:0] req_data;
    logic        soft_rst;
    logic [31:0] to_core;
    logic [31:0] from_core;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_payload;
    logic [1:0]  rsp_status;
    logic        busy;

    logic [3:0]  model_last;
    logic [7:0]  model_cb;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // Core model: current-cmd field mirrors the word it is being driven with.
    assign from_core = {16'h0, to_core[30:27], model_last, model_cb};

    pdh_cmd_master dut (
        .clk              (clk),
        .rst_ni           (rst_ni),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_cmd_i        (req_cmd),
        .req_data_i       (req_data),
        .soft_rst_i       (soft_rst),
        .gpio_to_core_o   (to_core),
        .gpio_from_core_i (from_core),
        .rsp_valid_o      (rsp_valid),
        .rsp_ready_i      (rsp_ready),
        .rsp_payload_o    (rsp_payload),
        .rsp_status_o     (rsp_status),
        .busy_o           (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single edge; ready must already be high.
    task automatic send(input logic [3:0] cmd, input logic [26:0] data);
        check("ready_before_req", 32'(req_ready), 32'h1);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_data  = data;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni     = 1'b0;
        req_valid  = 1'b0;
        req_cmd    = '0;
        req_data   = '0;
        soft_rst   = 1'b0;
        rsp_ready  = 1'b0;
        model_last = '0;
        model_cb   = '0;

        // Reset state
        tick();
        tick();
        check("rst_word",  to_core, 32'h0);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_valid", 32'(rsp_valid), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        rst_ni = 1'b1;
        #1;
        check("ready_before_first_clk", 32'(req_ready), 32'h0);
        tick();
        check("ready_after_release", 32'(req_ready), 32'h1);

        // SET_LED 0xA5, callback 0x5A
        model_last = 4'h1;
        model_cb   = 8'h5A;
        send(4'h1, 27'h0A5);
        for (int i = 0; i < 4; i++) begin
            check("led_setup_word", to_core, 32'h0800_00A5);
            check("led_setup_busy", 32'(busy), 32'h1);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            check("led_strobe_word",  to_core, 32'h7000_00A5);
            check("led_strobe_valid", 32'(rsp_valid), 32'h0);
            tick();
        end
        check("led_rsp_valid",   32'(rsp_valid), 32'h1);
        check("led_rsp_payload", 32'(rsp_payload), 32'h5A);
        check("led_rsp_status",  32'(rsp_status), 32'h0);
        check("led_resp_word",   to_core, 32'h0000_00A5);
        check("led_resp_ready",  32'(req_ready), 32'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("led_after_valid", 32'(rsp_valid), 32'h0);
        check("led_after_busy",  32'(busy), 32'h0);
        check("led_after_word",  to_core, 32'h0000_00A5);

        // SET_DAC 0x5FFF with a stalled consumer
        model_last = 4'h2;
        model_cb   = 8'h33;
        send(4'h2, 27'h5FFF);
        for (int i = 0; i < 4; i++) begin
            check("dac_setup_word", to_core, 32'h1000_5FFF);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            check("dac_strobe_word", to_core, 32'h7000_5FFF);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            check("dac_hold_valid",   32'(rsp_valid), 32'h1);
            check("dac_hold_payload", 32'(rsp_payload), 32'h33);
            check("dac_hold_status",  32'(rsp_status), 32'h0);
            check("dac_hold_word",    to_core, 32'h0000_5FFF);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("dac_idle_valid", 32'(rsp_valid), 32'h0);
        check("dac_idle_busy",  32'(busy), 32'h0);
        check("dac_idle_ready", 32'(req_ready), 32'h1);

        // Invalid command 0x5
        send(4'h5, 27'h123);
        check("rej_valid",   32'(rsp_valid), 32'h1);
        check("rej_status",  32'(rsp_status), 32'h2);
        check("rej_payload", 32'(rsp_payload), 32'h0);
        check("rej_word",    to_core, 32'h0000_5FFF);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rej_done_valid", 32'(rsp_valid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rej_no_strobe", to_core, 32'h0000_5FFF);
        end

        // Mismatch: core reports last cmd 0000 for a SET_LED
        model_last = 4'h0;
        model_cb   = 8'h11;
        send(4'h1, 27'h0A5);
        for (int i = 0; i < 8; i++) tick();
        check("mis_valid",   32'(rsp_valid), 32'h1);
        check("mis_status",  32'(rsp_status), 32'h1);
        check("mis_payload", 32'(rsp_payload), 32'h11);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Soft reset pulsed during setup
        model_last = 4'h1;
        model_cb   = 8'h42;
        send(4'h1, 27'h7);
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("srst_rsp_valid",  32'(rsp_valid), 32'h1);
        check("srst_rsp_status", 32'(rsp_status), 32'h0);
        check("srst_rsp_payload",32'(rsp_payload), 32'h42);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("srst_idle_word",  to_core, 32'h0000_0007);
        check("srst_idle_ready", 32'(req_ready), 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("srst_word",  to_core, 32'h8000_0000);
            check("srst_valid", 32'(rsp_valid), 32'h0);
            check("srst_busy",  32'(busy), 32'h1);
            tick();
        end
        check("srst_done_word",  to_core, 32'h0000_0000);
        check("srst_done_ready", 32'(req_ready), 32'h1);
        check("srst_done_busy",  32'(busy), 32'h0);

        // Async reset in the middle of a strobe
        model_last = 4'h2;
        model_cb   = 8'h77;
        send(4'h2, 27'h1234);
        for (int i = 0; i < 5; i++) tick();
        check("ar_pre_word", to_core, 32'h7000_1234);
        #2;
        rst_ni = 1'b0;
        #1;
        check("ar_word",  to_core, 32'h0);
        check("ar_valid", 32'(rsp_valid), 32'h0);
        check("ar_busy",  32'(busy), 32'h0);
        tick();
        tick();
        rst_ni = 1'b1;
        #1;
        check("ar_ready_pre", 32'(req_ready), 32'h0);
        tick();
        check("ar_ready_post", 32'(req_ready), 32'h1);
        check("ar_post_word",  to_core, 32'h0);
        check("ar_post_valid", 32'(rsp_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
